memory_interface: RTL and testbench

Word-addressed memory controller. It sits directly downstream of the CPU datapath and takes the MAR address and MDR store data from it. It performs single-outstanding reads and writes against an internal synchronous RAM, then returns load data to the MDR input together with a completion pulse for the control sequencer. Programmable wait states model slow memory so the sequencer's stall handling can be exercised.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_array_sp.sv | 30 +++
 rtl/memory_interface.sv | 139 +++++++++++++
 tb/tb_memory_interface.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared state encodings and default sizing for memory_interface.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_t;

    localparam int c_default_depth_log2  = 9;
    localparam int c_default_wait_states = 2;

endpackage
`default_nettype wire

// File: rtl/mem_array_sp.sv
`default_nettype none
// ============================================================================
// Module      : mem_array_sp
// Description : Single-port synchronous RAM, registered read-first output, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array_sp
    import mem_pkg::*;
#(
    parameter int ADDR_W = c_default_depth_log2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/memory_interface.sv
`default_nettype none
// ============================================================================
// Module      : memory_interface
// Description : Single-outstanding word-addressed RAM controller with optional
//               programmable wait states (enabled by MEM_WAIT_STATES_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module memory_interface
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = c_default_depth_log2,
    parameter int WAIT_STATES = c_default_wait_states
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] Maddress_in,
    input  logic [31:0] Mdata_wr,
    output logic [31:0] Mdata_in,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        addr_err
);

    mem_state_t            r_state;
    mem_state_t            w_next_state;
    logic                  w_accept;
    logic                  w_addr_err;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           w_ram_rdata;
    logic                  r_write;
    logic                  w_ram_we;

    assign w_accept   = (r_state == ST_IDLE) && (mem_read || mem_write);
    assign w_addr_err = |Maddress_in[31:DEPTH_LOG2];

    // The RAM read is registered, so present the incoming address while idle;
    // the word is then ready by ACCESS even without wait states.
    assign w_ram_addr = (r_state == ST_IDLE) ? Maddress_in[DEPTH_LOG2-1:0] : r_addr;

`ifdef MEM_WAIT_STATES_EN
    localparam mem_state_t  c_first_state = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
    localparam logic [3:0]  c_wait_init   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [3:0] r_wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
        end else if (w_accept) begin
            r_wait_cnt <= c_wait_init;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end
`else
    localparam mem_state_t c_first_state          = ST_ACCESS;
    localparam int         c_unused_wait_states   = WAIT_STATES;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_busy     = (r_state != ST_IDLE);
        mem_done     = 1'b0;
        w_ram_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_first_state;
                end
            end
`ifdef MEM_WAIT_STATES_EN
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = ST_ACCESS;
                end
            end
`endif
            ST_ACCESS: begin
                w_ram_we     = r_write && !addr_err;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                mem_done     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latches; write wins when both strobes are high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_write  <= 1'b0;
            addr_err <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= Maddress_in[DEPTH_LOG2-1:0];
            r_wdata  <= Mdata_wr;
            r_write  <= mem_write;
            addr_err <= w_addr_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Mdata_in <= 32'h0;
        end else if ((r_state == ST_ACCESS) && !r_write) begin
            Mdata_in <= addr_err ? 32'h0 : w_ram_rdata;
        end
    end

    mem_array_sp #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (32)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_memory_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_interface
// Description : Directed plus randomized self-checking bench for memory_interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_interface;

    localparam int TB_DEPTH_LOG2  = 9;
    localparam int TB_WAIT_STATES = 2;
`ifdef MEM_WAIT_STATES_EN
    localparam int EXP_LAT = (TB_WAIT_STATES == 0) ? 2 : TB_WAIT_STATES + 2;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] Maddress_in;
    logic [31:0] Mdata_wr;
    logic [31:0] Mdata_in;
    logic        mem_busy;
    logic        mem_done;
    logic        addr_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: word array indexed by in-range address
    logic [31:0] ref_mem   [0:(2**TB_DEPTH_LOG2)-1];
    bit          ref_valid [0:(2**TB_DEPTH_LOG2)-1];
    logic [31:0] ref_mdata;
    logic        ref_err;
    int          written_q[$];

    memory_interface #(
        .DEPTH_LOG2  (TB_DEPTH_LOG2),
        .WAIT_STATES (TB_WAIT_STATES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .Maddress_in (Maddress_in),
        .Mdata_wr    (Mdata_wr),
        .Mdata_in    (Mdata_in),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int idx;
        idx     = int'(addr[TB_DEPTH_LOG2-1:0]);
        ref_err = (addr >= (32'd1 << TB_DEPTH_LOG2));
        if (wr) begin
            if (!ref_err) begin
                ref_mem[idx] = data;
                if (!ref_valid[idx]) written_q.push_back(idx);
                ref_valid[idx] = 1'b1;
            end
        end else begin
            ref_mdata = ref_err ? 32'h0 : ref_mem[idx];
        end
    endtask

    // One request; optionally keeps mem_read high while busy to prove it is ignored.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, input logic inject_rd, input string tag);
        int lat;
        int busy_cnt;
        int extra_done;
        model_op(wr, addr, data);
        @(negedge clk);
        mem_write   = wr;
        mem_read    = rd;
        Maddress_in = addr;
        Mdata_wr    = data;
        @(posedge clk);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            mem_write   = 1'b0;
            mem_read    = inject_rd;
            Maddress_in = $urandom;
            Mdata_wr    = $urandom;
            if (mem_busy === 1'b1) busy_cnt++;
            if (mem_done === 1'b1) lat = k;
        end
        mem_read = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(EXP_LAT));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(EXP_LAT));
        check({tag, " addr_err"}, {31'h0, addr_err}, {31'h0, ref_err});
        check({tag, " Mdata_in"}, Mdata_in, ref_mdata);
        extra_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_done === 1'b1) extra_done++;
            if (k == 0) check({tag, " busy_after"}, {31'h0, mem_busy}, 32'h0);
        end
        check({tag, " extra_done"}, 32'(extra_done), 32'h0);
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;

        for (int i = 0; i < 2**TB_DEPTH_LOG2; i++) ref_valid[i] = 1'b0;
        ref_mdata   = 32'h0;
        ref_err     = 1'b0;
        reset       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        Maddress_in = 32'h0;
        Mdata_wr    = 32'h0;

        #3;
        check("reset Mdata_in", Mdata_in, 32'h0);
        check("reset mem_busy", {31'h0, mem_busy}, 32'h0);
        check("reset mem_done", {31'h0, mem_done}, 32'h0);
        check("reset addr_err", {31'h0, addr_err}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_busy !== 1'b0) busy_seen++;
        end
        check("idle busy", 32'(busy_seen), 32'h0);

        do_access(1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 1'b0, "wr5");
        do_access(1'b0, 1'b1, 32'd5, 32'h0, 1'b0, "rd5");

        do_access(1'b1, 1'b0, 32'd0, 32'h0BADF00D, 1'b0, "wr0");
        do_access(1'b1, 1'b0, 32'h200, 32'h00001234, 1'b0, "wr_oor");
        do_access(1'b0, 1'b1, 32'h200, 32'h0, 1'b0, "rd_oor");
        do_access(1'b0, 1'b1, 32'd0, 32'h0, 1'b0, "rd0");

        do_access(1'b1, 1'b1, 32'd7, 32'hA5A5A5A5, 1'b1, "both7");
        do_access(1'b0, 1'b1, 32'd7, 32'h0, 1'b0, "rd7");

        // Reset abort of a write to an address holding known data
        do_access(1'b1, 1'b0, 32'd9, 32'h11111111, 1'b0, "wr9");
        @(negedge clk);
        mem_write   = 1'b1;
        Maddress_in = 32'd9;
        Mdata_wr    = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("abort mem_busy", {31'h0, mem_busy}, 32'h0);
        check("abort mem_done", {31'h0, mem_done}, 32'h0);
        check("abort Mdata_in", Mdata_in, 32'h0);
        check("abort addr_err", {31'h0, addr_err}, 32'h0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_done !== 1'b0) done_seen++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_done !== 1'b0) done_seen++;
        end
        check("abort done_pulses", 32'(done_seen), 32'h0);
        ref_mdata = 32'h0;
        ref_err   = 1'b0;
        do_access(1'b0, 1'b1, 32'd9, 32'h0, 1'b0, "rd9_after_abort");

        // Randomized traffic against the array model
        for (int n = 0; n < 16; n++) begin
            w = ($urandom_range(0, 1) == 1);
            d = $urandom;
            case ($urandom_range(0, 3))
                0:       a = $urandom | 32'h200;
                default: a = w ? 32'($urandom_range(0, 2**TB_DEPTH_LOG2 - 1))
                               : 32'(written_q[$urandom_range(0, written_q.size() - 1)]);
            endcase
            do_access(w, !w || ($urandom_range(0, 3) == 0), a, d, 1'b0, w ? "rnd_wr" : "rnd_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
